// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing
// with memory-ready stalls, bus timeout and illegal-instruction trap. Macro: MCU_BRANCH_EXT_EN.
module multicycle_control_unit #(
    parameter int unsigned ULA_CTRL_W   = 3,
    parameter int unsigned WAIT_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            OP,
    input  logic [2:0]            Funct3,
    input  logic [6:0]            Funct7,
    input  logic                  Zero,
    input  logic                  Lt,
    input  logic                  MemReady,
    output logic                  PCWrite,
    output logic                  IRWrite,
    output logic                  RegWrite,
    output logic                  MemWrite,
    output logic                  AdrSrc,
    output logic [1:0]            ULASrcA,
    output logic [1:0]            ULASrcB,
    output logic [2:0]            ImmSrc,
    output logic [1:0]            ResultSrc,
    output logic [ULA_CTRL_W-1:0] ULAControl,
    output logic                  Illegal,
    output logic                  BusErr
);

    localparam int unsigned CNT_W = (WAIT_TIMEOUT == 0) ? 1 : $clog2(WAIT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (WAIT_TIMEOUT == 0) ? '0 : CNT_W'(WAIT_TIMEOUT - 1);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BRANCH, JAL, ERROR
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;

    logic             dec_legal, alu_f3_ok, br_taken, waiting;
    logic [2:0]       alu_i, alu_r, ula_ctrl;
    logic             pc_write, ir_write, reg_write, mem_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // Instruction legality and ULA operation decode from the IR fields.
    always_comb begin
        alu_f3_ok = (Funct3 == 3'b000) || (Funct3 == 3'b111) ||
                    (Funct3 == 3'b110) || (Funct3 == 3'b010);
        unique case (Funct3)
            3'b111:  alu_i = 3'b010;
            3'b110:  alu_i = 3'b011;
            3'b010:  alu_i = 3'b101;
            default: alu_i = 3'b000;
        endcase
        alu_r = ((Funct3 == 3'b000) && (Funct7 == 7'b0100000)) ? 3'b001 : alu_i;
        unique case (OP)
            OP_LOAD, OP_STORE: dec_legal = (Funct3 == 3'b000) || (Funct3 == 3'b010);
            OP_R:    dec_legal = ((Funct7 == 7'b0000000) && alu_f3_ok) ||
                                 ((Funct7 == 7'b0100000) && (Funct3 == 3'b000));
            OP_I:    dec_legal = alu_f3_ok;
`ifdef MCU_BRANCH_EXT_EN
            OP_BR:   dec_legal = (Funct3 == 3'b000) || (Funct3 == 3'b001) ||
                                 (Funct3 == 3'b100) || (Funct3 == 3'b101);
`else
            OP_BR:   dec_legal = (Funct3 == 3'b000);
`endif
            OP_JAL:  dec_legal = 1'b1;
            default: dec_legal = 1'b0;
        endcase
    end

    // Branch condition evaluated from the ULA flags.
`ifdef MCU_BRANCH_EXT_EN
    always_comb begin
        unique case (Funct3)
            3'b001:  br_taken = !Zero;
            3'b100:  br_taken = Lt;
            3'b101:  br_taken = !Lt;
            default: br_taken = Zero;
        endcase
    end
`else
    logic unused_lt;
    assign unused_lt = Lt;
    assign br_taken  = Zero;
`endif

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        AdrSrc    = 1'b0;
        ULASrcA   = 2'b00;
        ULASrcB   = 2'b00;
        ImmSrc    = 3'b000;
        ResultSrc = 2'b00;
        ula_ctrl  = 3'b000;
        waiting   = 1'b0;
        unique case (state_q)
            FETCH: begin
                ULASrcB   = 2'b10;
                ResultSrc = 2'b10;
                ir_write  = MemReady;
                pc_write  = MemReady;
                waiting   = 1'b1;
                if (MemReady) state_d = DECODE;
            end
            DECODE: begin
                ULASrcA = 2'b01;
                ULASrcB = 2'b01;
                ImmSrc  = (OP == OP_JAL) ? 3'b011 : 3'b010;
                if (!dec_legal) begin
                    state_d   = ERROR;
                    illegal_d = 1'b1;
                end else begin
                    unique case (OP)
                        OP_LOAD, OP_STORE: state_d = MEMADR;
                        OP_R:              state_d = EXECR;
                        OP_I:              state_d = EXECI;
                        OP_BR:             state_d = BRANCH;
                        default:           state_d = JAL;
                    endcase
                end
            end
            MEMADR: begin
                ULASrcA = 2'b10;
                ULASrcB = 2'b01;
                ImmSrc  = (OP == OP_LOAD) ? 3'b000 : 3'b001;
                state_d = (OP == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc  = 1'b1;
                waiting = 1'b1;
                if (MemReady) state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
                waiting   = 1'b1;
                if (MemReady) state_d = FETCH;
            end
            EXECR: begin
                ULASrcA  = 2'b10;
                ula_ctrl = alu_r;
                state_d  = ALUWB;
            end
            EXECI: begin
                ULASrcA  = 2'b10;
                ULASrcB  = 2'b01;
                ula_ctrl = alu_i;
                state_d  = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                ULASrcA  = 2'b10;
                ula_ctrl = 3'b001;
                pc_write = br_taken;
                state_d  = FETCH;
            end
            JAL: begin
                ULASrcA  = 2'b01;
                ULASrcB  = 2'b10;
                pc_write = 1'b1;
                state_d  = ALUWB;
            end
            default: state_d = ERROR;
        endcase
        // A ready on the final allowed cycle still completes the access.
        if (waiting && !MemReady && (WAIT_TIMEOUT != 0) && (wait_cnt_q == CNT_LAST)) begin
            state_d   = ERROR;
            bus_err_d = 1'b1;
        end
        wait_cnt_d = (waiting && !MemReady && (state_d == state_q)) ? wait_cnt_q + CNT_W'(1) : '0;
    end

    // Enables are held off for the whole reset window, including the FETCH ready path.
    assign PCWrite    = pc_write  & rst_n;
    assign IRWrite    = ir_write  & rst_n;
    assign RegWrite   = reg_write & rst_n;
    assign MemWrite   = mem_write & rst_n;
    assign ULAControl = ULA_CTRL_W'(ula_ctrl);
    assign Illegal    = illegal_q;
    assign BusErr     = bus_err_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: instruction-level model builds the
// expected per-cycle outputs, a negedge process compares them against the DUT.
module tb_multicycle_control_unit;

    localparam int unsigned TO = 4;
`ifdef MCU_BRANCH_EXT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3, P_MEMWB = 4,
                   P_MEMWRITE = 5, P_EXECR = 6, P_EXECI = 7, P_ALUWB = 8, P_BRANCH = 9,
                   P_JAL = 10, P_ERROR = 11, P_RESET = 12;

    typedef struct packed {
        logic       pcw, irw, rw, mw, adr;
        logic [1:0] sa, sb;
        logic [2:0] imm;
        logic [1:0] rs;
        logic [2:0] ula;
        logic       ill, bus;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [6:0] OP = '0;
    logic [2:0] Funct3 = '0;
    logic [6:0] Funct7 = '0;
    logic Zero = 1'b0, Lt = 1'b0, MemReady = 1'b0;
    logic PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
    logic [1:0] ULASrcA, ULASrcB, ResultSrc;
    logic [2:0] ImmSrc, ULAControl;
    logic Illegal, BusErr;

    multicycle_control_unit #(.ULA_CTRL_W(3), .WAIT_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .OP(OP), .Funct3(Funct3), .Funct7(Funct7),
        .Zero(Zero), .Lt(Lt), .MemReady(MemReady),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .ULASrcA(ULASrcA), .ULASrcB(ULASrcB), .ImmSrc(ImmSrc),
        .ResultSrc(ResultSrc), .ULAControl(ULAControl), .Illegal(Illegal), .BusErr(BusErr)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    vec_t exp_q[$];
    bit   exp_ill = 1'b0, exp_bus = 1'b0;
    bit   pending = 1'b0;
    int   instr_cycles;
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic [6:0] cur_f7;
    logic cur_zero, cur_lt;

    task automatic check_lit(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Per-cycle compare against the model queue.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            vec_t e, a;
            e = exp_q.pop_front();
            a = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ULASrcA, ULASrcB,
                 ImmSrc, ResultSrc, ULAControl, Illegal, BusErr};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_outputs @%0t op=%b f3=%b: got %b expected %b",
                         $time, OP, Funct3, a, e);
            end
        end
    end

    function automatic bit is_legal(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        bit alu3;
        alu3 = (f3 == 3'd0) || (f3 == 3'd7) || (f3 == 3'd6) || (f3 == 3'd2);
        case (op)
            7'b0110011: return (f7 == 7'd0 && alu3) || (f7 == 7'h20 && f3 == 3'd0);
            7'b0010011: return alu3;
            7'b0000011, 7'b0100011: return (f3 == 3'd0) || (f3 == 3'd2);
            7'b1100011: return (f3 == 3'd0) || (EXT && (f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5));
            7'b1101111: return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

    // ULA operation the instruction asks for: add/sub/and/or/slt codes.
    function automatic logic [2:0] op_code(input logic [2:0] f3, input bit is_sub);
        if (f3 == 3'd7) return 3'b010;
        if (f3 == 3'd6) return 3'b011;
        if (f3 == 3'd2) return 3'b101;
        return is_sub ? 3'b001 : 3'b000;
    endfunction

    function automatic bit taken(input logic [2:0] f3, input logic z, input logic lt);
        case (f3)
            3'd1:    return !z;
            3'd4:    return lt;
            3'd5:    return !lt;
            default: return z;
        endcase
    endfunction

    function automatic vec_t expect_out(input int ph, input logic mr);
        vec_t v;
        v = '0;
        case (ph)
            P_FETCH:    begin v.sb = 2'b10; v.rs = 2'b10; v.irw = mr; v.pcw = mr; end
            P_RESET:    begin v.sb = 2'b10; v.rs = 2'b10; end
            P_DECODE:   begin v.sa = 2'b01; v.sb = 2'b01; v.imm = (cur_op == 7'b1101111) ? 3'b011 : 3'b010; end
            P_MEMADR:   begin v.sa = 2'b10; v.sb = 2'b01; v.imm = (cur_op == 7'b0000011) ? 3'b000 : 3'b001; end
            P_MEMREAD:  v.adr = 1'b1;
            P_MEMWB:    begin v.rs = 2'b01; v.rw = 1'b1; end
            P_MEMWRITE: begin v.adr = 1'b1; v.mw = 1'b1; end
            P_EXECR:    begin v.sa = 2'b10; v.ula = op_code(cur_f3, cur_f7 == 7'h20); end
            P_EXECI:    begin v.sa = 2'b10; v.sb = 2'b01; v.ula = op_code(cur_f3, 1'b0); end
            P_ALUWB:    v.rw = 1'b1;
            P_BRANCH:   begin v.sa = 2'b10; v.ula = 3'b001; v.pcw = taken(cur_f3, cur_zero, cur_lt); end
            P_JAL:      begin v.sa = 2'b01; v.sb = 2'b10; v.pcw = 1'b1; end
            default:    ;
        endcase
        v.ill = exp_ill;
        v.bus = exp_bus;
        return v;
    endfunction

    task automatic cyc(input int ph, input logic mr);
        if (pending) pending = 1'b0;
        else begin @(posedge clk); #1; end
        OP = cur_op; Funct3 = cur_f3; Funct7 = cur_f7; Zero = cur_zero; Lt = cur_lt;
        MemReady = mr;
        exp_q.push_back(expect_out(ph, mr));
        instr_cycles++;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        MemReady = 1'b1;
        exp_ill = 1'b0; exp_bus = 1'b0;
        exp_q.push_back(expect_out(P_RESET, 1'b1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        pending = 1'b1;
    endtask

    task automatic wait_phase(input int ph, input int nwait, output bit err);
        err = 1'b0;
        for (int k = 0; k <= nwait; k++) begin
            logic mr;
            mr = (k >= nwait);
            cyc(ph, mr);
            if (mr) break;
            if (k + 1 == TO) begin
                err = 1'b1;
                exp_bus = 1'b1;
                break;
            end
        end
    endtask

    task automatic error_tail();
        for (int i = 0; i < 3; i++) cyc(P_ERROR, 1'b1);
        do_reset();
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic z, input logic lt, input int fw, input int mw);
        bit err;
        cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_zero = z; cur_lt = lt;
        instr_cycles = 0;
        wait_phase(P_FETCH, fw, err);
        if (err) begin error_tail(); return; end
        cyc(P_DECODE, 1'b1);
        if (!is_legal(op, f3, f7)) begin exp_ill = 1'b1; error_tail(); return; end
        case (op)
            7'b0000011: begin
                cyc(P_MEMADR, 1'b1);
                wait_phase(P_MEMREAD, mw, err);
                if (err) begin error_tail(); return; end
                cyc(P_MEMWB, 1'b1);
            end
            7'b0100011: begin
                cyc(P_MEMADR, 1'b1);
                wait_phase(P_MEMWRITE, mw, err);
                if (err) begin error_tail(); return; end
            end
            7'b0110011: begin cyc(P_EXECR, 1'b1); cyc(P_ALUWB, 1'b1); end
            7'b0010011: begin cyc(P_EXECI, 1'b1); cyc(P_ALUWB, 1'b1); end
            7'b1100011: cyc(P_BRANCH, 1'b1);
            default:    begin cyc(P_JAL, 1'b1); cyc(P_ALUWB, 1'b1); end
        endcase
    endtask

    initial begin
        cur_op = '0; cur_f3 = '0; cur_f7 = '0; cur_zero = 1'b0; cur_lt = 1'b0;
        do_reset();

        run_instr(7'b0110011, 3'd0, 7'h00, 1'b0, 1'b0, 0, 0);   // add
        check_lit("add_latency", instr_cycles, 4);
        run_instr(7'b0110011, 3'd0, 7'h20, 1'b0, 1'b0, 0, 0);   // sub
        run_instr(7'b0110011, 3'd2, 7'h00, 1'b0, 1'b0, 0, 0);   // slt
        run_instr(7'b0110011, 3'd7, 7'h00, 1'b0, 1'b0, 0, 0);   // and
        run_instr(7'b0010011, 3'd6, 7'h55, 1'b0, 1'b0, 0, 0);   // ori
        run_instr(7'b0010011, 3'd0, 7'h00, 1'b0, 1'b0, 1, 0);   // addi with fetch stall
        check_lit("addi_fetch_stall_latency", instr_cycles, 5);
        run_instr(7'b0000011, 3'd2, 7'h00, 1'b0, 1'b0, 0, 3);   // lw, ready at limit
        check_lit("load_3wait_latency", instr_cycles, 8);
        run_instr(7'b0100011, 3'd0, 7'h00, 1'b0, 1'b0, 0, 0);   // sb
        check_lit("store_latency", instr_cycles, 4);
        run_instr(7'b1100011, 3'd0, 7'h00, 1'b1, 1'b0, 0, 0);   // beq taken
        check_lit("beq_latency", instr_cycles, 3);
        run_instr(7'b1100011, 3'd0, 7'h00, 1'b0, 1'b1, 0, 0);   // beq not taken
        run_instr(7'b1101111, 3'd5, 7'h11, 1'b0, 1'b0, 0, 0);   // jal
        check_lit("jal_latency", instr_cycles, 4);

        run_instr(7'b1111111, 3'd0, 7'h00, 1'b0, 1'b0, 0, 0);   // bad opcode
        run_instr(7'b0110011, 3'd7, 7'h20, 1'b0, 1'b0, 0, 0);   // and with sub funct7
        run_instr(7'b0000011, 3'd1, 7'h00, 1'b0, 1'b0, 0, 0);   // lh unsupported
        run_instr(7'b1100011, 3'd1, 7'h00, 1'b0, 1'b0, 0, 0);   // bne, Zero=0
        run_instr(7'b1100011, 3'd4, 7'h00, 1'b1, 1'b1, 0, 0);   // blt, Lt=1
        run_instr(7'b1100011, 3'd5, 7'h00, 1'b0, 1'b1, 0, 0);   // bge, Lt=1

        run_instr(7'b0100011, 3'd2, 7'h00, 1'b0, 1'b0, 0, 50);  // sw, bus hang
        run_instr(7'b0010011, 3'd0, 7'h00, 1'b0, 1'b0, 50, 0);  // fetch hang

        // Store timeout pinned by hand: 4 MemWrite cycles then ERROR with BusErr.
        cur_op = 7'b0100011; cur_f3 = 3'd0; cur_f7 = '0; cur_zero = 1'b0; cur_lt = 1'b0;
        cyc(P_FETCH, 1'b1); cyc(P_DECODE, 1'b1); cyc(P_MEMADR, 1'b1);
        begin
            int mw_cycles;
            mw_cycles = 0;
            for (int i = 0; i < 8; i++) begin
                @(posedge clk); #1; MemReady = 1'b0;
                @(negedge clk);
                if (MemWrite === 1'b1) mw_cycles++;
                if (BusErr === 1'b1) break;
            end
            check_lit("store_timeout_memwrite_cycles", mw_cycles, 4);
            check_lit("store_timeout_buserr", int'(BusErr), 1);
            check_lit("error_enables_off", int'({PCWrite, IRWrite, RegWrite, MemWrite}), 0);
            check_lit("error_illegal_clear", int'(Illegal), 0);
        end
        exp_ill = 1'b0; exp_bus = 1'b1;
        do_reset();
        @(negedge clk);
        check_lit("reset_clears_buserr", int'(BusErr), 0);

        // Reset in the middle of a load: no write may occur.
        cur_op = 7'b0000011; cur_f3 = 3'd0;
        cyc(P_FETCH, 1'b1); cyc(P_DECODE, 1'b1); cyc(P_MEMADR, 1'b1);
        do_reset();
        run_instr(7'b0110011, 3'd6, 7'h00, 1'b0, 1'b0, 0, 0);   // or after abort

        @(negedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
